// File: rtl/goboard_glyph_arbiter_if.sv
// Requester-side bus of the glyph ROM arbiter: per-requester valid/ready lookups
// and the shared registered response.
interface goboard_glyph_arbiter_if #(
    parameter int unsigned NREQ   = 3,
    parameter int unsigned ADDR_W = 9,
    parameter int unsigned DATA_W = 8
);
    logic [NREQ-1:0]        req_i;
    logic [NREQ*ADDR_W-1:0] addr_i;
    logic [NREQ-1:0]        gnt_o;
    logic [NREQ-1:0]        rvalid_o;
    logic [DATA_W-1:0]      rdata_o;

    modport master (
        output req_i, addr_i,
        input  gnt_o, rvalid_o, rdata_o
    );

    modport slave (
        input  req_i, addr_i,
        output gnt_o, rvalid_o, rdata_o
    );
endinterface

// File: rtl/goboard_glyph_arbiter.sv
// Shares one glyph-row ROM between NREQ overlay renderers. Round-robin with a
// bounded burst per owner; responses return ROM_LAT+1 cycles after the transfer.
module goboard_glyph_arbiter #(
    parameter int unsigned NREQ      = 3,
    parameter int unsigned ADDR_W    = 9,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned ROM_LAT   = 1,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic                   clk,
    input  logic                   clr,
    goboard_glyph_arbiter_if.slave bus,
    output logic                   rom_en_o,
    output logic [ADDR_W-1:0]      rom_addr_o,
    input  logic [DATA_W-1:0]      rom_data_i
);
    localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NREQ - 1);
    localparam logic [3:0] BURST = 4'(MAX_BURST);

    logic [PTR_W-1:0]  ptr_q;
    logic [PTR_W-1:0]  owner_q;
    logic [3:0]        cnt_q;
    logic [PTR_W-1:0]  win;
    logic [PTR_W-1:0]  win_next;
    logic [3:0]        cnt_inc;
    logic [NREQ-1:0]   gnt;
    logic [ADDR_W-1:0] win_addr;
    logic              xfer;

    // Response id pipeline; stage 0 is loaded on the transfer edge.
    logic [NREQ-1:0]   pipe_q [ROM_LAT+1];
    logic [NREQ-1:0]   rvalid_q;
    logic [DATA_W-1:0] rdata_q;
    logic              rom_en_q;
    logic [ADDR_W-1:0] rom_addr_q;

    // Search pending requests starting at ptr_q; the first one found wins.
    always_comb begin
        int unsigned idx;
        logic        found;
        idx      = 0;
        found    = 1'b0;
        gnt      = '0;
        win      = '0;
        win_addr = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx = 32'(ptr_q) + i;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!found && bus.req_i[idx]) begin
                found         = 1'b1;
                gnt[idx]      = 1'b1;
                win           = PTR_W'(idx);
                win_addr      = bus.addr_i[idx*ADDR_W +: ADDR_W];
            end
        end
    end

    // Burst count for the winner and the ring index after it (wraps without overflow).
    always_comb begin
        cnt_inc  = (win != owner_q) ? 4'd1 : cnt_q + 4'd1;
        win_next = (win == LAST_IDX) ? '0 : win + PTR_W'(1);
    end

    assign xfer = |gnt;

    // Arbitration state: advance only on a transfer; a full burst hands priority onward.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            ptr_q   <= '0;
            owner_q <= '0;
            cnt_q   <= '0;
        end else if (xfer) begin
            owner_q <= win;
            if (cnt_inc == BURST) begin
                ptr_q <= win_next;
                cnt_q <= '0;
            end else begin
                ptr_q <= win;
                cnt_q <= cnt_inc;
            end
        end
    end

    // ROM strobe/address and the response pipeline; reset drops anything in flight.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            rom_en_q   <= 1'b0;
            rom_addr_q <= '0;
            rvalid_q   <= '0;
            rdata_q    <= '0;
            for (int unsigned s = 0; s <= ROM_LAT; s++) pipe_q[s] <= '0;
        end else begin
            rom_en_q  <= xfer;
            if (xfer) rom_addr_q <= win_addr;
            pipe_q[0] <= gnt;
            for (int unsigned s = 1; s <= ROM_LAT; s++) pipe_q[s] <= pipe_q[s-1];
            rvalid_q  <= pipe_q[ROM_LAT];
            if (|pipe_q[ROM_LAT]) rdata_q <= rom_data_i;
        end
    end

    assign bus.gnt_o    = gnt;
    assign bus.rvalid_o = rvalid_q;
    assign bus.rdata_o  = rdata_q;
    assign rom_en_o     = rom_en_q;
    assign rom_addr_o   = rom_addr_q;
endmodule

// File: tb/tb_goboard_glyph_arbiter.sv
// Directed bench for the glyph ROM arbiter: three instances cover default
// parameters, pure round-robin and a 4-requester / 3-cycle-ROM configuration.
module tb_goboard_glyph_arbiter;
    logic clk;
    logic clr;
    int   n_cmp;
    int   n_err;
    int   wait2;

    logic [2:0] vec_req [16];
    logic [2:0] vec_gnt [16];
    logic [2:0] rr_seq  [6];

    goboard_glyph_arbiter_if #(.NREQ(3), .ADDR_W(9), .DATA_W(8)) a_bus ();
    goboard_glyph_arbiter_if #(.NREQ(3), .ADDR_W(9), .DATA_W(8)) b_bus ();
    goboard_glyph_arbiter_if #(.NREQ(4), .ADDR_W(9), .DATA_W(8)) c_bus ();

    logic       a_rom_en, b_rom_en, c_rom_en;
    logic [8:0] a_rom_addr, b_rom_addr, c_rom_addr;
    logic [7:0] a_rom_data, b_rom_data, c_rom_data;
    logic [7:0] c_rom_pipe [3];

    goboard_glyph_arbiter #(.NREQ(3), .ADDR_W(9), .DATA_W(8), .ROM_LAT(1), .MAX_BURST(4)) u_dut_a (
        .clk        (clk),
        .clr        (clr),
        .bus        (a_bus),
        .rom_en_o   (a_rom_en),
        .rom_addr_o (a_rom_addr),
        .rom_data_i (a_rom_data)
    );

    goboard_glyph_arbiter #(.NREQ(3), .ADDR_W(9), .DATA_W(8), .ROM_LAT(1), .MAX_BURST(1)) u_dut_b (
        .clk        (clk),
        .clr        (clr),
        .bus        (b_bus),
        .rom_en_o   (b_rom_en),
        .rom_addr_o (b_rom_addr),
        .rom_data_i (b_rom_data)
    );

    goboard_glyph_arbiter #(.NREQ(4), .ADDR_W(9), .DATA_W(8), .ROM_LAT(3), .MAX_BURST(4)) u_dut_c (
        .clk        (clk),
        .clr        (clr),
        .bus        (c_bus),
        .rom_en_o   (c_rom_en),
        .rom_addr_o (c_rom_addr),
        .rom_data_i (c_rom_data)
    );

    // Glyph ROM contents: 0x045 -> 0x3C, 0x0AB -> 0xD2, 0x1A2 -> 0xDA, 0x007 -> 0x7E.
    function automatic logic [7:0] rom_f(input logic [8:0] a);
        return a[7:0] ^ 8'h79 ^ {7'd0, a[8]};
    endfunction

    always @(posedge clk) a_rom_data <= rom_f(a_rom_addr);
    always @(posedge clk) b_rom_data <= rom_f(b_rom_addr);
    always @(posedge clk) begin
        c_rom_pipe[0] <= rom_f(c_rom_addr);
        c_rom_pipe[1] <= c_rom_pipe[0];
        c_rom_pipe[2] <= c_rom_pipe[1];
    end
    assign c_rom_data = c_rom_pipe[2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        clr = 1'b1;
        a_bus.req_i = '0;
        b_bus.req_i = '0;
        c_bus.req_i = '0;
        tick();
        tick();
        clr = 1'b0;
    endtask

    task automatic set_vec(input int c, input logic [2:0] r, input logic [2:0] g);
        vec_req[c] = r;
        vec_gnt[c] = g;
    endtask

    // Drives vec_req on instance A one cycle at a time; checks the grant that cycle
    // and the response of the transfer issued three drive slots earlier.
    task automatic run_a_vectors(input string name, input int n);
        logic [2:0] exp_rv;
        for (int c = 0; c < n; c++) begin
            a_bus.req_i = vec_req[c];
            exp_rv = (c >= 3) ? vec_gnt[c-3] : 3'b000;
            check_eq($sformatf("%s_rvalid_c%0d", name, c), 32'(a_bus.rvalid_o), 32'(exp_rv));
            #1;
            check_eq($sformatf("%s_gnt_c%0d", name, c), 32'(a_bus.gnt_o), 32'(vec_gnt[c]));
            if (a_bus.req_i[2] && !a_bus.gnt_o[2]) wait2++;
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        wait2 = 0;
        clr = 1'b1;
        a_bus.req_i = '0;  a_bus.addr_i = '0;
        b_bus.req_i = '0;  b_bus.addr_i = '0;
        c_bus.req_i = '0;  c_bus.addr_i = '0;
        tick();
        tick();

        // Reset state, and grant following req_i while clr is high.
        check_eq("rst_rom_en", 32'(a_rom_en), 32'd0);
        check_eq("rst_rom_addr", 32'(a_rom_addr), 32'd0);
        check_eq("rst_rvalid", 32'(a_bus.rvalid_o), 32'd0);
        check_eq("rst_rdata", 32'(a_bus.rdata_o), 32'd0);
        a_bus.req_i = 3'b100;
        #1;
        check_eq("rst_gnt_follow", 32'(a_bus.gnt_o), 32'b100);
        a_bus.req_i = '0;
        clr = 1'b0;

        // Single request from requester 1.
        a_bus.req_i = 3'b010;
        a_bus.addr_i[9 +: 9] = 9'h045;
        #1;
        check_eq("single_gnt", 32'(a_bus.gnt_o), 32'b010);
        tick();
        a_bus.req_i = '0;
        check_eq("single_rom_en", 32'(a_rom_en), 32'd1);
        check_eq("single_rom_addr", 32'(a_rom_addr), 32'h045);
        check_eq("single_rvalid_e1", 32'(a_bus.rvalid_o), 32'd0);
        tick();
        check_eq("single_rvalid_e2m", 32'(a_bus.rvalid_o), 32'd0);
        check_eq("single_rom_en_off", 32'(a_rom_en), 32'd0);
        check_eq("single_rom_addr_hold", 32'(a_rom_addr), 32'h045);
        tick();
        check_eq("single_rvalid", 32'(a_bus.rvalid_o), 32'b010);
        check_eq("single_rdata", 32'(a_bus.rdata_o), 32'h3C);
        tick();
        check_eq("single_rvalid_off", 32'(a_bus.rvalid_o), 32'd0);
        check_eq("single_rdata_hold", 32'(a_bus.rdata_o), 32'h3C);

        // Pure round-robin contention on instance B; includes the wrap from index 2.
        pulse_reset();
        rr_seq[0] = 3'b001; rr_seq[1] = 3'b010; rr_seq[2] = 3'b100;
        rr_seq[3] = 3'b001; rr_seq[4] = 3'b010; rr_seq[5] = 3'b100;
        for (int c = 0; c < 9; c++) begin
            b_bus.req_i = (c < 6) ? 3'b111 : 3'b000;
            check_eq($sformatf("rr_rvalid_c%0d", c), 32'(b_bus.rvalid_o),
                     32'((c >= 3) ? rr_seq[c-3] : 3'b000));
            #1;
            check_eq($sformatf("rr_gnt_c%0d", c), 32'(b_bus.gnt_o),
                     32'((c < 6) ? rr_seq[c] : 3'b000));
            tick();
        end

        // Burst limit on instance A: req 0 continuous, req 2 pends from cycle 1.
        pulse_reset();
        set_vec(0, 3'b001, 3'b001);
        for (int c = 1; c < 4; c++) set_vec(c, 3'b101, 3'b001);
        set_vec(4, 3'b101, 3'b100);
        for (int c = 5; c < 10; c++) set_vec(c, 3'b001, 3'b001);
        for (int c = 10; c < 13; c++) set_vec(c, 3'b000, 3'b000);
        wait2 = 0;
        run_a_vectors("burst", 13);
        check_eq("burst_wait2", 32'(wait2), 32'd3);

        // Yield: req 0 drops after two transfers, grant moves to 1 at once.
        pulse_reset();
        set_vec(0, 3'b011, 3'b001);
        set_vec(1, 3'b011, 3'b001);
        set_vec(2, 3'b010, 3'b010);
        for (int c = 3; c < 6; c++) set_vec(c, 3'b000, 3'b000);
        run_a_vectors("yield", 6);

        // Reset mid-flight: in-flight responses vanish and ptr returns to 0.
        pulse_reset();
        a_bus.req_i = 3'b001;
        a_bus.addr_i = '0;
        a_bus.addr_i[0 +: 9] = 9'h011;
        a_bus.addr_i[9 +: 9] = 9'h0AB;
        a_bus.addr_i[18 +: 9] = 9'h122;
        #1;
        check_eq("mid_gnt0", 32'(a_bus.gnt_o), 32'b001);
        tick();
        a_bus.req_i = 3'b100;
        #1;
        check_eq("mid_gnt2", 32'(a_bus.gnt_o), 32'b100);
        tick();
        a_bus.req_i = 3'b110;
        #1;
        check_eq("mid_gnt_ptr2", 32'(a_bus.gnt_o), 32'b100);
        clr = 1'b1;
        #1;
        check_eq("mid_gnt_in_clr", 32'(a_bus.gnt_o), 32'b010);
        check_eq("mid_rom_en_clr", 32'(a_rom_en), 32'd0);
        check_eq("mid_rvalid_clr", 32'(a_bus.rvalid_o), 32'd0);
        tick();
        check_eq("mid_rvalid_drop1", 32'(a_bus.rvalid_o), 32'd0);
        check_eq("mid_rom_en_clr2", 32'(a_rom_en), 32'd0);
        tick();
        check_eq("mid_rvalid_drop2", 32'(a_bus.rvalid_o), 32'd0);
        clr = 1'b0;
        #1;
        check_eq("mid_gnt_release", 32'(a_bus.gnt_o), 32'b010);
        tick();
        a_bus.req_i = '0;
        check_eq("mid_rom_en_new", 32'(a_rom_en), 32'd1);
        check_eq("mid_rom_addr_new", 32'(a_rom_addr), 32'h0AB);
        check_eq("mid_rvalid_new0", 32'(a_bus.rvalid_o), 32'd0);
        tick();
        check_eq("mid_rvalid_new1", 32'(a_bus.rvalid_o), 32'd0);
        tick();
        check_eq("mid_rvalid_new", 32'(a_bus.rvalid_o), 32'b010);
        check_eq("mid_rdata_new", 32'(a_bus.rdata_o), 32'hD2);

        // Instance C: back-to-back transfers from requester 3 then 0, ROM_LAT=3.
        pulse_reset();
        c_bus.req_i = 4'b1000;
        c_bus.addr_i[27 +: 9] = 9'h1A2;
        #1;
        check_eq("lat3_gnt3", 32'(c_bus.gnt_o), 32'b1000);
        tick();
        check_eq("lat3_rom_en1", 32'(c_rom_en), 32'd1);
        check_eq("lat3_rom_addr1", 32'(c_rom_addr), 32'h1A2);
        c_bus.req_i = 4'b0001;
        c_bus.addr_i[0 +: 9] = 9'h007;
        #1;
        check_eq("lat3_gnt0", 32'(c_bus.gnt_o), 32'b0001);
        tick();
        c_bus.req_i = '0;
        check_eq("lat3_rom_en2", 32'(c_rom_en), 32'd1);
        check_eq("lat3_rom_addr2", 32'(c_rom_addr), 32'h007);
        for (int c = 3; c < 8; c++) begin
            tick();
            if (c == 3) check_eq("lat3_rom_en_off", 32'(c_rom_en), 32'd0);
            check_eq($sformatf("lat3_rvalid_c%0d", c), 32'(c_bus.rvalid_o),
                     (c == 5) ? 32'b1000 : (c == 6) ? 32'b0001 : 32'd0);
            if (c == 5) check_eq("lat3_rdata3", 32'(c_bus.rdata_o), 32'hDA);
            if (c == 6) check_eq("lat3_rdata0", 32'(c_bus.rdata_o), 32'h7E);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
